// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            is_op32,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] x);
    return {{HW{x[HW-1]}}, x};
  endfunction

  // W ops keep their magnitude in the low half so the shared datapath runs 32 steps.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic w, input logic neg);
    logic [XLEN-1:0] t;
    t = neg ? -x : x;
    return w ? {{HW{1'b0}}, t[HW-1:0]} : t;
  endfunction

  function automatic logic [XLEN-1:0] mul_res(input logic [2*XLEN-1:0] p, input logic [1:0] f3lo,
                                              input logic w);
    if (w) return sext_w(p[HW-1:0]);
    return (f3lo == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic            is_div, s1, s2, a_neg, b_neg, b_zero, ovf, illegal, bypass, accept, last;
  logic [XLEN-1:0] a_mag, b_mag, op1_ext, bypass_res;

  // Latched operation context and shared accumulators.
  logic [1:0]      f3_q;
  logic            op32_q, neg_q, neg_r;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opa_q;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == (op32_q ? CW'(HW - 1) : CW'(XLEN - 1)));

  always_comb begin
    is_div  = funct3[2];
    s1      = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    s2      = is_div ? ~funct3[0] : ~funct3[1];
    a_neg   = s1 & (is_op32 ? op1[HW-1] : op1[XLEN-1]);
    b_neg   = s2 & (is_op32 ? op2[HW-1] : op2[XLEN-1]);
    a_mag   = mag(op1, is_op32, a_neg);
    b_mag   = mag(op2, is_op32, b_neg);
    op1_ext = is_op32 ? sext_w(op1[HW-1:0]) : op1;
    b_zero  = is_op32 ? (op2[HW-1:0] == '0) : (op2 == '0);
    ovf     = is_div & ~funct3[0] &
              (is_op32 ? (op1[HW-1:0] == {1'b1, {(HW-1){1'b0}}} && op2[HW-1:0] == '1)
                       : (op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1));
    illegal = is_op32 & ~is_div & (funct3[1:0] != 2'b00);
    bypass  = illegal | (is_div & (b_zero | ovf));
    bypass_res = '0;
    if (is_div & b_zero) bypass_res = funct3[1] ? op1_ext : '1;
    else if (ovf)        bypass_res = funct3[1] ? '0 : op1_ext;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  logic [XLEN-1:0]   fast_res;
  always_comb begin
    fast_p = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    if (a_neg ^ b_neg) fast_p = -fast_p;
    fast_res = mul_res(fast_p, funct3[1:0], is_op32);
  end
`endif

  // One iteration of either algorithm; {hi,lo} is the product / {remainder,quotient} pair.
  logic [XLEN:0]     msum, rs;
  logic [XLEN-1:0]   diff, nhi, nlo, qf, rf, dsel, res_final;
  logic [2*XLEN-1:0] pm, pmf;
  logic              ge;

  always_comb begin
    msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    rs   = {hi_q, lo_q[XLEN-1]};
    ge   = (rs >= {1'b0, opa_q});
    diff = rs[XLEN-1:0] - opa_q;
    if (state_q == S_DIV) begin
      nhi = ge ? diff : rs[XLEN-1:0];
      nlo = {lo_q[XLEN-2:0], ge};
    end else begin
      nhi = msum[XLEN:1];
      nlo = {msum[0], lo_q[XLEN-1:1]};
    end
    pm   = {nhi, nlo};
    pmf  = neg_q ? -pm : pm;
    qf   = neg_q ? -nlo : nlo;
    rf   = neg_r ? -nhi : nhi;
    dsel = f3_q[1] ? rf : qf;
    // A 32-step multiply leaves its product in bits [2*XLEN-1:HW].
    if (state_q == S_DIV) res_final = op32_q ? sext_w(dsel[HW-1:0]) : dsel;
    else res_final = mul_res(op32_q ? (pmf >> HW) : pmf, f3_q, op32_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (bypass)      state_d = S_DONE;
        else if (is_div) state_d = S_DIV;
        else begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = S_DONE;
`else
          state_d = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: if (last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q       <= '0;
      op32_q     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opa_q      <= '0;
      out_result <= '0;
    end else if (!flush) begin
      if (accept) begin
        f3_q   <= funct3[1:0];
        op32_q <= is_op32;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        cnt_q  <= '0;
        hi_q   <= '0;
        if (bypass) out_result <= bypass_res;
        else if (is_div) begin
          opa_q <= b_mag;
          lo_q  <= is_op32 ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          out_result <= fast_res;
`else
          opa_q <= a_mag;
          lo_q  <= b_mag;
`endif
        end
      end else if (state_q == S_MUL || state_q == S_DIV) begin
        hi_q <= nhi;
        lo_q <= nlo;
        if (last) out_result <= res_final;
        else      cnt_q      <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  request present (decoded OP/OP_32 with funct7=0000001).
REQ-005 in_ready  out  1  unit can accept; high only in IDLE.
REQ-006 funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 is_op32  in  1  W-variant: operate on op[31:0], sign-extend the 32-bit result.
REQ-008 op1, op2  in  XLEN each  rs1 and rs2 values.
REQ-009 flush  in  1  kill in-flight operation.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 out_result  out  XLEN  result, stable while out_valid=1.

Function
REQ-013 States: IDLE, MUL, DIV, DONE; IDLE->MUL or DIV on accept (in_valid & in_ready); MUL/DIV->DONE after final iteration; DONE->IDLE on out_ready.
REQ-014 Operands, funct3 and is_op32 are latched at accept; later input changes have no effect.
REQ-015 Iteration count N=64, or 32 when is_op32=1; an op accepted at cycle T asserts out_valid first at T+N+1.
REQ-016 Multiply: shift-add over magnitudes with sign fix-up; MULH/MULHSU/MULHU return bits [127:64] of the signed*signed, signed*unsigned, and unsigned*unsigned product; MUL returns bits [63:0].
REQ-017 Divide: restoring, one quotient bit per cycle on magnitudes; quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
REQ-018 Divide by zero: DIV and DIVU return all-ones; REM and REMU return the dividend; these bypass iteration, with out_valid at T+1.
REQ-019 Signed overflow (most-negative / -1, at 64 or 32 bits): DIV returns the dividend; REM returns 0; out_valid at T+1.
REQ-020 is_op32=1 with funct3 001-011 is not legal; the unit returns 0 at T+1.
REQ-021 W results are {32{r[31]}, r[31:0]}.
REQ-022 In DONE, out_valid stays high and out_result holds until out_ready=1.
REQ-023 out_valid and out_ready both high at cycle C: in_ready=1 at C+1; there is no same-cycle re-accept.
REQ-024 flush in any state: next state is IDLE; out_valid=0 in the next cycle; no result is produced.
REQ-025 flush takes priority over accept in the same cycle; the request is dropped.
REQ-026 The iteration counter never wraps: it saturates at N-1 and then exits.

Reset
REQ-027 On rst the unit goes to IDLE asynchronously, with in_ready=1, out_valid=0, out_result=0, and the counter and accumulators cleared.
REQ-028 Reset mid-operation discards the operation; the first result after reset comes only from a new accept.

Configuration
REQ-029 MULDIV_FAST_MUL_EN defined: MUL* use a single-cycle multiplier with out_valid at T+1, and the MUL state is unreachable.
REQ-030 MULDIV_FAST_MUL_EN undefined: MUL* iterate per REQ-015/016; divide behaviour is identical either way.

Verification
REQ-031 MUL op1=7 op2=-3 -> out_result=0xFFFFFFFFFFFFFFEB; out_valid at T+65 (T+1 with fast mul).
REQ-032 DIV op1=-20 op2=6 -> result -3; REM -> -2; DIVU op1=20 op2=0 -> all-ones, out_valid at T+1.
REQ-033 DIVW op1=0x80000000 op2=0xFFFFFFFF -> 0xFFFFFFFF80000000; REMW of the same operands -> 0; out_valid at T+1.
REQ-034 MULHU op1=op2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; hold out_ready=0 for 5 cycles -> out_valid and out_result stable throughout.
REQ-035 DIVU accepted, flush at T+10 -> out_valid never rises, in_ready=1 at T+11, and the next MUL 2*3 -> 6.
REQ-036 rst pulsed at T+20 during DIV -> out_valid=0 and in_ready=1 immediately, with no stale result after rst deasserts.
